// File: rtl/openram_gpio_packet_shifter.sv
// Serial GPIO front end for the OpenRAM test chip. Deserialises a command packet
// MSB first, strobes it out in parallel, then captures and serialises the result word.
module openram_gpio_packet_shifter #(
  parameter int PACKET_WIDTH = 86,
  parameter int RESULT_WIDTH = 64,
  parameter int READ_LATENCY = 3
) (
  input  logic                    gpio_clock,
  input  logic                    reset,
  input  logic                    gpio_start,
  input  logic                    gpio_in,
  output logic [PACKET_WIDTH-1:0] packet_out,
  output logic                    packet_valid,
  input  logic [RESULT_WIDTH-1:0] result_in,
  output logic                    gpio_out,
  output logic                    gpio_out_valid,
  output logic                    busy
);

  localparam int MAXW = (PACKET_WIDTH > RESULT_WIDTH) ? PACKET_WIDTH : RESULT_WIDTH;
  localparam int CW   = $clog2(MAXW + 1);

  typedef enum logic [2:0] {IDLE, SHIFT_IN, ISSUE, WAIT, SHIFT_OUT} state_e;

  state_e                  state_q, state_d;
  logic [CW-1:0]           cnt_q, cnt_d;
  logic [PACKET_WIDTH-1:0] sh_q, sh_d;
  logic [PACKET_WIDTH-1:0] pkt_q, pkt_d;
  logic [RESULT_WIDTH-1:0] res_q, res_d;
  logic [PACKET_WIDTH-1:0] sh_next;

  assign sh_next = {sh_q[PACKET_WIDTH-2:0], gpio_in};

  always_ff @(posedge gpio_clock) begin
    if (!reset) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // Down-counter hits zero on the last cycle of each phase.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:      if (gpio_start)     state_d = SHIFT_IN;
      SHIFT_IN:  if (cnt_q == '0)    state_d = ISSUE;
      ISSUE:                         state_d = WAIT;
      WAIT:      if (cnt_q == '0)    state_d = SHIFT_OUT;
      SHIFT_OUT: if (cnt_q == '0)    state_d = IDLE;
      default:                       state_d = IDLE;
    endcase
  end

  always_comb begin
    packet_valid   = (state_q == ISSUE);
    gpio_out_valid = (state_q == SHIFT_OUT);
    gpio_out       = (state_q == SHIFT_OUT) & res_q[RESULT_WIDTH-1];
    busy           = (state_q != IDLE);
  end

  always_comb begin
    cnt_d = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    if (state_d != state_q) begin
      case (state_d)
        SHIFT_IN:  cnt_d = CW'(PACKET_WIDTH - 1);
        WAIT:      cnt_d = CW'(READ_LATENCY - 1);
        SHIFT_OUT: cnt_d = CW'(RESULT_WIDTH - 1);
        default:   cnt_d = '0;
      endcase
    end
  end

  // The final bit is folded in on the edge into ISSUE so packet_out is
  // already new during the packet_valid cycle.
  always_comb begin
    sh_d  = sh_q;
    pkt_d = pkt_q;
    res_d = res_q;
    if (state_q == SHIFT_IN) begin
      sh_d = sh_next;
      if (cnt_q == '0) pkt_d = sh_next;
    end
    if (state_q == WAIT && cnt_q == '0) res_d = result_in;
    if (state_q == SHIFT_OUT)           res_d = {res_q[RESULT_WIDTH-2:0], 1'b0};
  end

  always_ff @(posedge gpio_clock) begin
    if (!reset) begin
      cnt_q <= '0;
      sh_q  <= '0;
      pkt_q <= '0;
      res_q <= '0;
    end else begin
      cnt_q <= cnt_d;
      sh_q  <= sh_d;
      pkt_q <= pkt_d;
      res_q <= res_d;
    end
  end

  assign packet_out = pkt_q;

endmodule

// File: tb/tb_openram_gpio_packet_shifter.sv
// Directed bench for the GPIO packet shifter: per-cycle driver/monitor with a
// latency-checked result model and a small SRAM model for the loop test.
module tb_openram_gpio_packet_shifter;

  localparam int PW = 86;
  localparam int RW = 64;
  localparam int RL = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          gpio_start = 1'b0;
  logic          gpio_in = 1'b0;
  logic [PW-1:0] packet_out;
  logic          packet_valid;
  logic [RW-1:0] result_in = '0;
  logic          gpio_out, gpio_out_valid, busy;

  int total = 0;
  int bad   = 0;

  logic [63:0] mem [8][4];
  bit          model_en = 1'b0;

  always #5 clk = ~clk;

  openram_gpio_packet_shifter #(.PACKET_WIDTH(PW), .RESULT_WIDTH(RW), .READ_LATENCY(RL)) dut (
    .gpio_clock(clk), .reset(rst_n), .gpio_start(gpio_start), .gpio_in(gpio_in),
    .packet_out(packet_out), .packet_valid(packet_valid), .result_in(result_in),
    .gpio_out(gpio_out), .gpio_out_valid(gpio_out_valid), .busy(busy));

  task automatic chk(input string tag, input logic [127:0] got, input logic [127:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [PW-1:0] mk_pkt(input logic [2:0] sel, input logic [27:0] addr,
                                           input logic web, input logic [31:0] data);
    return {sel, addr, web, 1'b0, 4'd15, 8'd1, data, 1'b0, 8'd0};
  endfunction

  // Runs one transaction starting in the current cycle (cycle 0 = start pulse).
  // result_in carries rv only on the capture cycle; garbage elsewhere.
  task automatic send(input logic [PW-1:0] pkt, input logic [RW-1:0] rv, input bit extra,
                      input logic [PW-1:0] prev, output logic [PW-1:0] got,
                      output int pv_cyc, output int pv_cnt, output logic [RW-1:0] ser,
                      output int nser, output int blen, output bit stable);
    logic [RW-1:0] mrd;
    int cyc;
    got = '0; pv_cyc = -1; pv_cnt = 0; ser = '0; nser = 0; blen = -1; stable = 1'b1;
    mrd = rv;
    cyc = 0;
    while (cyc < 400) begin
      if (cyc > 0 && !busy) begin
        blen = cyc;
        break;
      end
      if (packet_valid) begin
        pv_cnt++;
        pv_cyc = cyc;
        got = packet_out;
        if (model_en) begin
          if (!packet_out[54]) mem[packet_out[85:83]][packet_out[56:55]] = {32'd0, packet_out[40:9]};
          mrd = mem[packet_out[85:83]][packet_out[56:55]];
        end
      end else if (pv_cnt == 0 && packet_out !== prev) stable = 1'b0;
      if (gpio_out_valid) begin
        ser = {ser[RW-2:0], gpio_out};
        nser++;
      end
      gpio_start = (cyc == 0) || (extra && (cyc == 40 || cyc == 100 || cyc == 154));
      gpio_in    = (cyc >= 1 && cyc <= PW) ? pkt[PW-cyc] : 1'($urandom);
      result_in  = (pv_cyc >= 0 && cyc == pv_cyc + RL) ? mrd : 64'hDEAD_BEEF_CAFE_F00D;
      @(posedge clk); #1;
      cyc++;
    end
    gpio_start = 1'b0;
    if (blen < 0) chk("timeout", 1, 0);
  endtask

  initial begin
    logic [PW-1:0] p, got, p5;
    logic [RW-1:0] ser;
    int pvc, pvn, ns, bl;
    bit st;

    for (int s = 0; s < 8; s++) for (int a = 0; a < 4; a++) mem[s][a] = '0;

    repeat (2) @(posedge clk);
    #1;
    chk("rst_pkt", packet_out, 0);
    chk("rst_pv", packet_valid, 0);
    chk("rst_gout", gpio_out, 0);
    chk("rst_gov", gpio_out_valid, 0);
    chk("rst_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // T2 write packet
    p = {3'd0, 28'd0, 1'b0, 1'b0, 4'd15, 8'd1, 32'd1, 1'b0, 8'd0};
    send(p, 64'h0123_4567_89AB_CDEF, 0, '0, got, pvc, pvn, ser, ns, bl, st);
    chk("t2_pkt", got, p);
    chk("t2_pv_cyc", pvc, PW + 1);
    chk("t2_pv_cnt", pvn, 1);
    chk("t2_len", bl, 155);
    chk("t2_ser", ser, 64'h0123_4567_89AB_CDEF);
    chk("t2_nser", ns, RW);
    chk("t2_hold", packet_out, p);

    // T3 read path, result 5
    send(mk_pkt(3'd1, 28'd7, 1'b1, 32'd0), 64'd5, 0, p, got, pvc, pvn, ser, ns, bl, st);
    chk("t3_ser", ser, 64'd5);
    chk("t3_nser", ns, RW);
    chk("t3_len", bl, 155);
    chk("t3_hold", st, 1);

    // T5 back-to-back on the first IDLE cycle
    p = got;
    p5 = mk_pkt(3'd5, 28'h0ABCDEF, 1'b1, 32'hA5A5_5A5A);
    send(p5, 64'hFFFF_0000_1234_8001, 0, p, got, pvc, pvn, ser, ns, bl, st);
    chk("t5_pkt", got, p5);
    chk("t5_stable", st, 1);
    chk("t5_ser", ser, 64'hFFFF_0000_1234_8001);

    // T4 starts while busy, including the last SHIFT_OUT cycle
    p = mk_pkt(3'd2, 28'h5555555, 1'b0, 32'h8000_0001);
    send(p, 64'h8000_0000_0000_0001, 1, p5, got, pvc, pvn, ser, ns, bl, st);
    chk("t4_len", bl, 155);
    chk("t4_pv_cnt", pvn, 1);
    chk("t4_pkt", got, p);
    repeat (3) @(posedge clk);
    #1;
    chk("t4_idle", busy, 0);

    // T1 reset mid SHIFT_IN
    gpio_start = 1'b1;
    @(posedge clk); #1;
    gpio_start = 1'b0;
    for (int i = 0; i < 20; i++) begin
      gpio_in = 1'($urandom);
      @(posedge clk); #1;
    end
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("t1_pkt", packet_out, 0);
    chk("t1_pv", packet_valid, 0);
    chk("t1_gov", gpio_out_valid, 0);
    chk("t1_busy", busy, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;
    chk("t1_busy_after", busy, 0);
    p = mk_pkt(3'd7, 28'hFFFFFFF, 1'b1, 32'hFFFF_FFFF);
    send(p, 64'd9, 0, '0, got, pvc, pvn, ser, ns, bl, st);
    chk("t1_pkt_after", got, p);
    chk("t1_pv_cyc", pvc, PW + 1);
    chk("t1_ser", ser, 64'd9);

    // T6 loop through an SRAM model
    model_en = 1'b1;
    send(mk_pkt(3'd3, 28'd3, 1'b0, 32'd3), '0, 0, p, got, pvc, pvn, ser, ns, bl, st);
    send(mk_pkt(3'd3, 28'd3, 1'b1, 32'd0), '0, 0, got, got, pvc, pvn, ser, ns, bl, st);
    chk("t6_ser", ser, 64'd3);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
